// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave register bank for the matrix accelerator.
// Provides NUM_REGS byte-strobed 32-bit control registers. Their contents are
// exported flat on reg_q, and each commit pulses reg_wr_stb for one cycle.
// Unmapped indices answer SLVERR.
// Optional feature macro: AXIL_REGBANK_STATUS_EN. When it is defined, the top
// NUM_RO indices become read-only status registers fed from status_in.
module axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 16,
  parameter int NUM_RO             = 4
) (
  input  logic                                    S_AXI_ACLK,
  input  logic                                    S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic [2:0]                              S_AXI_AWPROT,
  input  logic                                    S_AXI_AWVALID,
  output logic                                    S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                    S_AXI_WVALID,
  output logic                                    S_AXI_WREADY,
  output logic [1:0]                              S_AXI_BRESP,
  output logic                                    S_AXI_BVALID,
  input  logic                                    S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic [2:0]                              S_AXI_ARPROT,
  input  logic                                    S_AXI_ARVALID,
  output logic                                    S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                              S_AXI_RRESP,
  output logic                                    S_AXI_RVALID,
  input  logic                                    S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]                  reg_q,
  output logic [NUM_REGS-1:0]                     reg_wr_stb,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] status_in
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
`ifdef AXIL_REGBANK_STATUS_EN
  // First read-only status index; everything from here up is status.
  localparam int RO_BASE = NUM_REGS - NUM_RO;
`else
  localparam int RO_BASE = NUM_REGS;
`endif

  localparam logic [1:0] WR_IDLE   = 2'd0;
  localparam logic [1:0] WR_COMMIT = 2'd1;
  localparam logic [1:0] WR_RESP   = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]       r_wr_state;
  logic             r_ready_en;
  logic             r_aw_held;
  logic             r_w_held;
  logic [IDX_W-1:0] r_aw_idx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_regs [NUM_REGS];
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic [IDX_W-1:0]    w_aw_idx;
  logic [IDX_W-1:0]    w_ar_idx;
  logic                w_awready;
  logic                w_wready;
  logic                w_arready;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic                w_commit;
  logic                w_wr_mapped;
  logic                w_wr_ro;
  logic [NUM_REGS-1:0] w_wr_sel;
  logic [31:0]         w_rd_data;
  logic [1:0]          w_rd_resp;
  logic                w_unused;

  function automatic logic idx_mapped(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  function automatic logic idx_ro(input logic [IDX_W-1:0] idx);
    return 32'(idx) >= 32'(RO_BASE);
  endfunction

  assign w_aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // r_ready_en keeps every READY low while in reset and releases them on the
  // first clock after reset is removed.
  assign w_awready = r_ready_en && (r_wr_state == WR_IDLE) && !r_aw_held;
  assign w_wready  = r_ready_en && (r_wr_state == WR_IDLE) && !r_w_held;
  assign w_arready = r_ready_en && !r_rvalid;

  assign w_aw_hs = S_AXI_AWVALID && w_awready;
  assign w_w_hs  = S_AXI_WVALID && w_wready;
  assign w_ar_hs = S_AXI_ARVALID && w_arready;

  assign w_commit    = (r_wr_state == WR_COMMIT);
  assign w_wr_mapped = idx_mapped(r_aw_idx);
  assign w_wr_ro     = idx_ro(r_aw_idx);

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BVALID  = (r_wr_state == WR_COMMIT) || (r_wr_state == WR_RESP);
  assign S_AXI_BRESP   = (S_AXI_BVALID && !w_wr_mapped) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_wr_stb    = w_wr_sel;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      assign w_wr_sel[g] = w_commit && w_wr_mapped && !w_wr_ro &&
                           (r_aw_idx == IDX_W'(g));
      assign reg_q[32*g +: 32] = (g >= RO_BASE) ? 32'd0 : r_regs[g];
    end
  endgenerate

`ifdef AXIL_REGBANK_STATUS_EN
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      status_in};
`endif

  // Write FSM: collect AW and W independently, commit once, then hold B.
  // A B handshake that completes during the commit cycle itself returns the
  // FSM straight to idle, so one write never produces two responses.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_state <= WR_IDLE;
      r_ready_en <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs) r_aw_held <= 1'b1;
          if (w_w_hs)  r_w_held  <= 1'b1;
          if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) r_wr_state <= WR_COMMIT;
        end
        WR_COMMIT: begin
          r_aw_held  <= 1'b0;
          r_w_held   <= 1'b0;
          r_wr_state <= S_AXI_BREADY ? WR_IDLE : WR_RESP;
        end
        WR_RESP: begin
          if (S_AXI_BREADY) r_wr_state <= WR_IDLE;
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Capture write address index and data/strobes on their handshakes.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_aw_hs) r_aw_idx <= w_aw_idx;
    if (w_w_hs) begin
      r_wdata <= S_AXI_WDATA[31:0];
      r_wstrb <= S_AXI_WSTRB[3:0];
    end
  end

  // Register file: byte-merge the captured write into the selected register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_sel[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux over current register state; unmapped indices fall through to 0.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = idx_mapped(w_ar_idx) ? RESP_OKAY : RESP_SLVERR;
    for (int i = 0; i < RO_BASE; i++) begin
      if (w_ar_idx == IDX_W'(i)) w_rd_data = r_regs[i];
    end
`ifdef AXIL_REGBANK_STATUS_EN
    for (int j = 0; j < NUM_RO; j++) begin
      if (w_ar_idx == IDX_W'(RO_BASE + j)) w_rd_data = status_in[32*j +: 32];
    end
`endif
  end

  // Read channel: register the response on AR handshake and hold it until RREADY.
  // The register file updates on the same edge, so a colliding commit is not
  // visible to this read.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Testbench for axil_regbank (NUM_REGS=12, NUM_RO=4, 6-bit addresses).
// A behavioural register-map model predicts read data, responses, reg_q and
// the number of reg_wr_stb pulses per register.
module tb_axil_regbank;
  localparam int AW   = 6;
  localparam int NREG = 12;
  localparam int NRO  = 4;
`ifdef AXIL_REGBANK_STATUS_EN
  localparam int RO_FIRST = NREG - NRO;
`else
  localparam int RO_FIRST = NREG;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   S_AXI_AWADDR = '0;
  logic [2:0]      S_AXI_AWPROT = '0;
  logic            S_AXI_AWVALID = 1'b0;
  logic            S_AXI_AWREADY;
  logic [31:0]     S_AXI_WDATA = '0;
  logic [3:0]      S_AXI_WSTRB = '0;
  logic            S_AXI_WVALID = 1'b0;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY = 1'b0;
  logic [AW-1:0]   S_AXI_ARADDR = '0;
  logic [2:0]      S_AXI_ARPROT = '0;
  logic            S_AXI_ARVALID = 1'b0;
  logic            S_AXI_ARREADY;
  logic [31:0]     S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY = 1'b0;
  logic [NREG*32-1:0] reg_q;
  logic [NREG-1:0]    reg_wr_stb;
  logic [NRO*32-1:0]  status_in = {32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 32'hCAFE0001};

  axil_regbank #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NREG), .NUM_RO(NRO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .reg_wr_stb(reg_wr_stb), .status_in(status_in)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int stb_cnt [NREG] = '{default: 0};
  int m_stb   [NREG] = '{default: 0};
  logic [31:0] m_regs [NREG] = '{default: 32'd0};

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) if (reg_wr_stb[i]) stb_cnt[i]++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: register map rules applied directly.
  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (idx >= NREG) resp = 2'b10;
    else begin
      resp = 2'b00;
      if (idx < RO_FIRST) begin
        for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
        m_stb[idx]++;
      end
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (idx >= NREG) begin d = 32'd0; resp = 2'b10; end
    else if (idx >= RO_FIRST) begin d = status_in[32*(idx-RO_FIRST) +: 32]; resp = 2'b00; end
    else begin d = m_regs[idx]; resp = 2'b00; end
  endtask

  function automatic logic [NREG*32-1:0] model_regq();
    logic [NREG*32-1:0] v;
    for (int i = 0; i < NREG; i++) v[32*i +: 32] = (i >= RO_FIRST) ? 32'd0 : m_regs[i];
    return v;
  endfunction

  // lead > 0: W is presented lead cycles before AW; lead < 0: AW first.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] resp);
    int n = 0;
    int t = 0;
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_go, w_go;
    @(negedge clk);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    while (!(aw_done && w_done) && n < 40) begin
      if (!aw_done) S_AXI_AWVALID = (t >= ((lead > 0) ? lead : 0));
      if (!w_done)  S_AXI_WVALID  = (t >= ((lead < 0) ? -lead : 0));
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge clk);
      t++; n++;
      if (aw_go) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_go)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("wr_addr_data_accepted", {511'd0, aw_done && w_done}, 512'd1);
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
    check("wr_bvalid_seen", {511'd0, S_AXI_BVALID}, 512'd1);
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
    check("rd_rvalid_seen", {511'd0, S_AXI_RVALID}, 512'd1);
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(negedge clk);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic write_and_check(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int lead);
    logic [1:0] resp, eresp;
    axi_write(a, d, s, lead, resp);
    model_write(a, d, s, eresp);
    check({tag, "_bresp"}, 512'(resp), 512'(eresp));
    check({tag, "_reg_q"}, 512'(reg_q), 512'(model_regq()));
  endtask

  task automatic read_and_check(input string tag, input logic [AW-1:0] a);
    logic [31:0] d, ed;
    logic [1:0] resp, eresp;
    axi_read(a, d, resp);
    model_read(a, ed, eresp);
    check({tag, "_rdata"}, 512'(d), 512'(ed));
    check({tag, "_rresp"}, 512'(resp), 512'(eresp));
  endtask

  initial begin
    logic [127:0] lo;
    logic [31:0]  old2, d;
    logic [1:0]   resp;
    int           s0, ssum;

    // Reset held over several edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 512'(S_AXI_AWREADY), 512'd0);
    check("rst_arready", 512'(S_AXI_ARREADY), 512'd0);
    check("rst_bvalid_rvalid", 512'({S_AXI_BVALID, S_AXI_RVALID}), 512'd0);
    check("rst_reg_q", 512'(reg_q), 512'd0);
    check("rst_rdata", 512'(S_AXI_RDATA), 512'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_readies", 512'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 512'd7);

    // Basic write/readback of registers 0..3.
    for (int i = 0; i < 4; i++) write_and_check("basic_wr", AW'(4*i), 32'(i + 1), 4'hF, 0);
    for (int i = 0; i < 4; i++) read_and_check("basic_rd", AW'(4*i));
    lo = reg_q[127:0];
    check("basic_reg_q_low", 512'(lo), 512'({32'd4, 32'd3, 32'd2, 32'd1}));

    // Byte strobes on register 1.
    s0 = stb_cnt[1];
    write_and_check("strb_full", 6'h04, 32'hAABBCCDD, 4'hF, 0);
    write_and_check("strb_0101", 6'h04, 32'h11223344, 4'b0101, 0);
    read_and_check("strb_rd", 6'h04);
    check("strb_value", 512'(m_regs[1]), 512'(32'hAA22CC44));
    check("strb_pulses", 512'(stb_cnt[1] - s0), 512'd2);

    // W three cycles ahead of AW, BREADY held low for five cycles.
    s0 = stb_cnt[2];
    old2 = m_regs[2];
    @(negedge clk);
    S_AXI_WDATA = 32'h000000A5; S_AXI_WSTRB = 4'hF; S_AXI_AWADDR = 6'h08;
    S_AXI_WVALID = 1'b1;
    check("lead_wready", 512'(S_AXI_WREADY), 512'd1);
    @(negedge clk); S_AXI_WVALID = 1'b0;
    check("lead_wready_dropped", 512'(S_AXI_WREADY), 512'd0);
    @(negedge clk); @(negedge clk);
    S_AXI_AWVALID = 1'b1;
    check("lead_awready", 512'(S_AXI_AWREADY), 512'd1);
    @(negedge clk); S_AXI_AWVALID = 1'b0;
    check("lead_commit_stb", 512'(reg_wr_stb), 512'(12'b100));
    check("lead_reg_q_pre", 512'(reg_q[95:64]), 512'(old2));
    for (int i = 0; i < 5; i++) begin
      check("lead_bvalid_hold", 512'({S_AXI_BVALID, S_AXI_BRESP}), 512'(3'b100));
      check("lead_awready_low", 512'(S_AXI_AWREADY), 512'd0);
      @(negedge clk);
    end
    model_write(6'h08, 32'h000000A5, 4'hF, resp);
    check("lead_reg_q_post", 512'(reg_q), 512'(model_regq()));
    S_AXI_BREADY = 1'b1;
    @(negedge clk); S_AXI_BREADY = 1'b0;
    check("lead_bvalid_done", 512'(S_AXI_BVALID), 512'd0);
    check("lead_single_commit", 512'(stb_cnt[2] - s0), 512'd1);

    // Unmapped index 15.
    ssum = 0; for (int i = 0; i < NREG; i++) ssum += stb_cnt[i];
    write_and_check("unmapped_wr", 6'h3C, 32'h12345678, 4'hF, 0);
    read_and_check("unmapped_rd", 6'h3C);
    s0 = 0; for (int i = 0; i < NREG; i++) s0 += stb_cnt[i];
    check("unmapped_no_stb", 512'(s0), 512'(ssum));

    // Read colliding with the commit of a write to the same register.
    write_and_check("coll_pre", 6'h08, 32'h7, 4'hF, 0);
    @(negedge clk);
    S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("coll_commit_stb", 512'(reg_wr_stb), 512'(12'b100));
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1;
    check("coll_arready", 512'(S_AXI_ARREADY), 512'd1);
    @(negedge clk);
    S_AXI_ARVALID = 1'b0; S_AXI_BREADY = 1'b0;
    check("coll_rvalid", 512'(S_AXI_RVALID), 512'd1);
    check("coll_old_value", 512'(S_AXI_RDATA), 512'(32'h7));
    S_AXI_RREADY = 1'b1;
    @(negedge clk); S_AXI_RREADY = 1'b0;
    model_write(6'h08, 32'h55, 4'hF, resp);
    read_and_check("coll_new_value", 6'h08);

    // Top index: status register when enabled, ordinary register otherwise.
    s0 = stb_cnt[NREG-1];
    write_and_check("top_wr", AW'(4*(NREG-1)), 32'h0, 4'hF, 0);
    read_and_check("top_rd", AW'(4*(NREG-1)));
    check("top_stb", 512'(stb_cnt[NREG-1] - s0), 512'(m_stb[NREG-1] - s0));

    // Randomized traffic with random AW/W skew and ignored low address bits.
    for (int k = 0; k < 60; k++) begin
      logic [AW-1:0] a;
      a = AW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        write_and_check("rand_wr", a, $urandom, 4'($urandom_range(0, 15)),
                        int'($urandom_range(0, 4)) - 2);
      else
        read_and_check("rand_rd", a);
    end
    for (int i = 0; i < NREG; i++) check("rand_stb_count", 512'(stb_cnt[i]), 512'(m_stb[i]));

    // Reset asserted with a B and an R response both outstanding.
    @(negedge clk);
    S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("midrst_pending", 512'({S_AXI_BVALID, S_AXI_RVALID}), 512'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_readies", 512'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 512'd0);
    check("midrst_valids", 512'({S_AXI_BVALID, S_AXI_RVALID}), 512'd0);
    check("midrst_resps", 512'({S_AXI_BRESP, S_AXI_RRESP}), 512'd0);
    check("midrst_rdata", 512'(S_AXI_RDATA), 512'd0);
    check("midrst_reg_q", 512'(reg_q), 512'd0);
    check("midrst_stb", 512'(reg_wr_stb), 512'd0);
    for (int i = 0; i < NREG; i++) m_regs[i] = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rerst_readies", 512'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 512'd7);
    read_and_check("rerst_rd0", 6'h00);
    axi_read(6'h04, d, resp);
    check("rerst_rd1", 512'(d), 512'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
